// File: rtl/pulse_flash_if.sv
// rtl/pulse_flash_if.sv - event strobe in, indicator/status out for pulse_flash
interface pulse_flash_if #(
  parameter int PEND_W = 3
);
  logic              pulse_in;
  logic              flash_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              ovf;

  modport master (output pulse_in, input flash_out, busy, pending, ovf);
  modport slave  (input pulse_in, output flash_out, busy, pending, ovf);
endinterface

// File: rtl/pulse_flash.sv
// rtl/pulse_flash.sv - stretches event pulses into fixed flashes with a dark gap, queueing extras
module pulse_flash #(
  parameter int ON_CYCLES  = 2000,
  parameter int OFF_CYCLES = 2000,
  parameter int CNT_W      = 14,
  parameter int PEND_W     = 3
) (
  input  logic            clk,
  input  logic            rst,
  pulse_flash_if.slave    bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              flash_r;
  logic [PEND_W-1:0] pend;
  logic              ovf_r;

  logic              gap_done;
  logic              queuing;
  logic              consume;
  logic [PEND_W-1:0] pend_nxt;
  logic              ovf_nxt;

  // A pulse on the consuming cycle cancels the decrement, so a full queue never drops it.
  always_comb begin
    gap_done = (state == S_GAP) && (cnt == OFF_LAST);
    queuing  = bus.pulse_in && (state != S_IDLE);
    consume  = gap_done && ((pend != '0) || bus.pulse_in);
    pend_nxt = pend;
    ovf_nxt  = ovf_r;
    if (consume && !queuing) begin
      pend_nxt = pend - PEND_W'(1);
    end else if (queuing && !consume) begin
      if (pend == PEND_MAX) ovf_nxt = 1'b1;
      else                  pend_nxt = pend + PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      flash_r <= 1'b0;
      pend    <= '0;
      ovf_r   <= 1'b0;
    end else begin
      pend  <= pend_nxt;
      ovf_r <= ovf_nxt;
      case (state)
        S_IDLE: begin
          if (bus.pulse_in) begin
            state   <= S_ON;
            cnt     <= '0;
            flash_r <= 1'b1;
          end
        end
        S_ON: begin
          if (cnt == ON_LAST) begin
            state   <= S_GAP;
            cnt     <= '0;
            flash_r <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (gap_done) begin
            cnt <= '0;
            if (consume) begin
              state   <= S_ON;
              flash_r <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          cnt     <= '0;
          flash_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.flash_out = flash_r;
  assign bus.busy      = (state != S_IDLE);
  assign bus.pending   = pend;
  assign bus.ovf       = ovf_r;
endmodule
